// File: rtl/ram_responder.sv
// Word-serial RAM endpoint for the cache/RAM link: collects write bursts into a line
// buffer, commits them in one edge, and streams read bursts back with ram_ack.
module ram_responder #(
    parameter int ADDR_SIZE     = 13,
    parameter int WORD_SIZE     = 16,
    parameter int BURST_LEN     = 4,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 ram_clk,
    input  logic                 ram_rst,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic [WORD_SIZE-1:0] ram_wdata,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    output logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int DEPTH   = 2 ** (ADDR_SIZE + BEAT_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, WCOLLECT, WWAIT, RWAIT, RBURST} state_t;

    state_t               state;
    logic [ADDR_SIZE-1:0] line;
    logic [BEAT_W-1:0]    beat;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_SIZE-1:0] line_buf [BURST_LEN];
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic                 commit;

    assign commit = (state == WCOLLECT) && ram_avalid && !ram_rnw && (beat == LAST_BEAT);

    // Whole line lands in one edge; the final word comes straight from the bus.
    always_ff @(posedge ram_clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < BURST_LEN; i++) begin
                mem[{line, BEAT_W'(i)}] <= (BEAT_W'(i) == LAST_BEAT) ? ram_wdata
                                                                      : line_buf[BEAT_W'(i)];
            end
        end
    end

    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            state        <= IDLE;
            line         <= '0;
            beat         <= '0;
            cnt          <= '0;
            ram_rdata    <= '0;
            ram_ack      <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
            for (int unsigned i = 0; i < BURST_LEN; i++) begin
                line_buf[BEAT_W'(i)] <= '0;
            end
        end else begin
            ram_ack      <= 1'b0;
            ram_rdata    <= '0;
            protocol_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_avalid) begin
                        line <= ram_addr;
                        busy <= 1'b1;
                        if (ram_rnw) begin
                            cnt   <= CNT_W'(READ_LATENCY - 1);
                            state <= RWAIT;
                        end else begin
                            line_buf[0] <= ram_wdata;
                            beat        <= BEAT_W'(1);
                            state       <= WCOLLECT;
                        end
                    end
                end
                WCOLLECT: begin
                    if (ram_avalid) begin
                        if (ram_rnw) begin
                            protocol_err <= 1'b1;
                            beat         <= '0;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else if (beat == LAST_BEAT) begin
                            // Loaded one higher than the read counter: the ack-issue
                            // edge is part of this count, whereas reads spend it in RBURST.
                            cnt   <= CNT_W'(WRITE_LATENCY);
                            beat  <= '0;
                            state <= WWAIT;
                        end else begin
                            line_buf[beat] <= ram_wdata;
                            beat           <= beat + BEAT_W'(1);
                        end
                    end
                end
                WWAIT: begin
                    protocol_err <= ram_avalid;
                    if (cnt == '0) begin
                        ram_ack <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RWAIT: begin
                    protocol_err <= ram_avalid;
                    if (cnt == '0) begin
                        beat  <= '0;
                        state <= RBURST;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RBURST: begin
                    protocol_err <= ram_avalid;
                    ram_ack      <= 1'b1;
                    ram_rdata    <= mem[{line, beat}];
                    beat         <= beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: vector table of bursts plus hand sequences for protocol
// errors and mid-burst reset; acks and error pulses are checked against a cycle scoreboard.
module tb_ram_responder;

    localparam int AW = 13;
    localparam int WW = 16;
    localparam int BL = 4;
    localparam int RL = 3;
    localparam int WL = 2;
    localparam int NV = 8;

    logic          ram_clk = 1'b0;
    logic          ram_rst = 1'b1;
    logic [AW-1:0] ram_addr = '0;
    logic [WW-1:0] ram_wdata = '0;
    logic          ram_avalid = 1'b0;
    logic          ram_rnw = 1'b0;
    logic [WW-1:0] ram_rdata;
    logic          ram_ack;
    logic          busy;
    logic          protocol_err;

    ram_responder #(
        .ADDR_SIZE(AW), .WORD_SIZE(WW), .BURST_LEN(BL),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_avalid(ram_avalid), .ram_rnw(ram_rnw),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .busy(busy),
        .protocol_err(protocol_err)
    );

    always #5 ram_clk = ~ram_clk;

    int cyc = 0;
    always @(posedge ram_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [WW-1:0] data; } exp_t;
    typedef struct {
        bit                   rd;
        logic [AW-1:0]        addr;
        logic [BL-1:0][WW-1:0] d;
        int                   gap;
    } vec_t;

    exp_t ack_q[$];
    int   err_q[$];
    exp_t mon_e;
    vec_t vecs[NV];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    always @(negedge ram_clk) begin
        if (ram_ack) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(ram_ack), 32'd0);
            end else begin
                mon_e = ack_q.pop_front();
                check("ack_cycle", cyc, mon_e.cyc);
                check("ack_data", 32'(ram_rdata), 32'(mon_e.data));
            end
        end else begin
            check("rdata_zero_without_ack", 32'(ram_rdata), 32'd0);
            if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
                check("ack_missing", 32'(ram_ack), 32'd1);
                void'(ack_q.pop_front());
            end
        end
        if (protocol_err) begin
            if (err_q.size() == 0) check("err_unexpected", 32'(protocol_err), 32'd0);
            else check("err_cycle", cyc, err_q.pop_front());
        end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
            check("err_missing", 32'(protocol_err), 32'd1);
            void'(err_q.pop_front());
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [BL-1:0][WW-1:0] d, input int gap);
        int last;
        last = 0;
        for (int b = 0; b < BL; b++) begin
            if (b > 0) begin
                repeat (gap) begin
                    ram_avalid = 1'b0;
                    ram_addr   = AW'($urandom);
                    @(negedge ram_clk); #1;
                end
            end
            ram_avalid = 1'b1;
            ram_rnw    = 1'b0;
            ram_addr   = (b == 0) ? a : AW'($urandom);
            ram_wdata  = d[b];
            last       = cyc + 1;
            @(negedge ram_clk); #1;
            if (b == 0) check("busy_after_first_beat", 32'(busy), 32'd1);
        end
        ram_avalid = 1'b0;
        ack_q.push_back('{last + WL + 1, '0});
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [BL-1:0][WW-1:0] d);
        int n;
        ram_avalid = 1'b1;
        ram_rnw    = 1'b1;
        ram_addr   = a;
        n          = cyc + 1;
        @(negedge ram_clk); #1;
        ram_avalid = 1'b0;
        ram_rnw    = 1'b0;
        for (int i = 0; i < BL; i++) ack_q.push_back('{n + RL + 1 + i, d[i]});
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ack_q.size() != 0 || err_q.size() != 0) && k < 60) begin
            @(negedge ram_clk); #1;
            k++;
        end
        check("drain_timeout", ack_q.size() + err_q.size(), 32'd0);
        check("busy_when_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(negedge ram_clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{rd: 1'b0, addr: 13'h0005, d: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, gap: 0};
        vecs[1] = '{rd: 1'b1, addr: 13'h0005, d: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, gap: 0};
        vecs[2] = '{rd: 1'b0, addr: 13'h0000, d: {16'hA003, 16'hA002, 16'hA001, 16'hA000}, gap: 0};
        vecs[3] = '{rd: 1'b0, addr: 13'h1FFF, d: {16'h0001, 16'hF00D, 16'hCAFE, 16'hBEEF}, gap: 2};
        vecs[4] = '{rd: 1'b1, addr: 13'h1FFF, d: {16'h0001, 16'hF00D, 16'hCAFE, 16'hBEEF}, gap: 0};
        vecs[5] = '{rd: 1'b1, addr: 13'h0000, d: {16'hA003, 16'hA002, 16'hA001, 16'hA000}, gap: 0};
        vecs[6] = '{rd: 1'b0, addr: 13'h0010, d: {16'h0013, 16'h0012, 16'h0011, 16'h0010}, gap: 0};
        vecs[7] = '{rd: 1'b1, addr: 13'h0010, d: {16'h0013, 16'h0012, 16'h0011, 16'h0010}, gap: 0};

        repeat (3) @(negedge ram_clk);
        check("reset_ack", 32'(ram_ack), 32'd0);
        check("reset_rdata", 32'(ram_rdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(protocol_err), 32'd0);
        #1 ram_rst = 1'b0;
        @(negedge ram_clk); #1;

        // Vector table, each entry issued as soon as the previous one completes.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rd) do_read(vecs[i].addr, vecs[i].d);
            else do_write(vecs[i].addr, vecs[i].d, vecs[i].gap);
            drain();
        end

        // Read command in the middle of a write burst aborts it without touching memory.
        for (int b = 0; b < 2; b++) begin
            ram_avalid = 1'b1;
            ram_rnw    = 1'b0;
            ram_addr   = 13'h0010;
            ram_wdata  = 16'hDEA0 + 16'(b);
            @(negedge ram_clk); #1;
        end
        check("busy_partial_write", 32'(busy), 32'd1);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b1;
        err_q.push_back(cyc + 1);
        @(negedge ram_clk); #1;
        ram_avalid = 1'b0;
        ram_rnw    = 1'b0;
        drain();
        do_read(13'h0010, vecs[7].d);
        drain();

        // Stray beat during a read burst: error pulse, burst and memory unaffected.
        do_read(13'h0005, vecs[1].d);
        n = cyc;
        err_q.push_back(n + 5);
        wait_until(n + 4);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
        ram_wdata  = 16'hFFFF;
        @(negedge ram_clk); #1;
        ram_avalid = 1'b0;
        drain();
        do_read(13'h0005, vecs[1].d);
        drain();

        // Reset after the second word of a burst drops outputs at once.
        do_read(13'h1FFF, vecs[4].d);
        n = cyc;
        wait_until(n + 5);
        check("midburst_ack_before_reset", 32'(ram_ack), 32'd1);
        #2 ram_rst = 1'b1;
        #1;
        check("async_reset_ack", 32'(ram_ack), 32'd0);
        check("async_reset_rdata", 32'(ram_rdata), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        ack_q.delete();
        @(negedge ram_clk); #1;
        ram_rst = 1'b0;
        @(negedge ram_clk); #1;
        do_read(13'h1FFF, vecs[4].d);
        drain();
        do_read(13'h0000, vecs[5].d);
        drain();

        repeat (3) @(negedge ram_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
